// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 icode constants, fetch states and instruction sizing helpers
package y86_pkg;

    localparam int FETCH_INST_W = 48;
    localparam int ICODE_LSB    = 44;

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVL = 4'h2;
    localparam logic [3:0] IC_IRMOVL = 4'h3;
    localparam logic [3:0] IC_RMMOVL = 4'h4;
    localparam logic [3:0] IC_MRMOVL = 4'h5;
    localparam logic [3:0] IC_OPL    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHL  = 4'hA;
    localparam logic [3:0] IC_POPL   = 4'hB;

    typedef enum logic [2:0] {
        ST_FETCH0,
        ST_FETCHN,
        ST_OUT,
        ST_HALTED,
        ST_ERROR
    } fetch_state_e;

    // Returns {len, valid}; an unknown icode reports length 1 so the byte can still be delivered.
    function automatic logic [3:0] ilen_f(input logic [3:0] icode);
        case (icode)
            IC_HALT, IC_NOP, IC_RET:               return {3'd1, 1'b1};
            IC_RRMOVL, IC_OPL, IC_PUSHL, IC_POPL:  return {3'd2, 1'b1};
            IC_JXX, IC_CALL:                       return {3'd5, 1'b1};
            IC_IRMOVL, IC_RMMOVL, IC_MRMOVL:       return {3'd6, 1'b1};
            default:                               return {3'd1, 1'b0};
        endcase
    endfunction

    // Byte lane (0 = bits [7:0]) that instruction byte k (1..5) lands in.
    function automatic logic [2:0] byte_lane(input logic [3:0] icode, input logic [2:0] k);
        if (icode == IC_JXX || icode == IC_CALL) begin
            return k;
        end else if (k == 3'd1) begin
            return 3'd4;
        end else begin
            return k - 3'd2;
        end
    endfunction

endpackage

// File: rtl/y86_ilen.sv
// rtl/y86_ilen.sv - combinational icode to instruction length decoder
module y86_ilen
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic [2:0] o_len,
    output logic       o_valid
);

    assign {o_len, o_valid} = ilen_f(i_icode);

endmodule

// File: rtl/y86_fetch.sv
// rtl/y86_fetch.sv - byte-serial instruction fetch and packing front end for decode
module y86_fetch
    import y86_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INST_W   = FETCH_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr_o,
    output logic              imem_req_o,
    input  logic              imem_ack_i,
    input  logic [7:0]        imem_rdata_i,
    input  logic              imem_err_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [2:0]        len_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              halted_o,
    output logic              err_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [PC_W-1:0]   r_pc;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [INST_W-1:0] r_inst;
    logic              r_err;

    logic [2:0]        w_len;
    logic              w_len_ok;
    logic              w_last;
    logic [2:0]        w_lane;
    logic [3:0]        w_icode;

    y86_ilen u_ilen (
        .i_icode (imem_rdata_i[7:4]),
        .o_len   (w_len),
        .o_valid (w_len_ok)
    );

    assign w_icode = r_inst[ICODE_LSB +: 4];
    assign w_last  = (r_cnt == r_len - 3'd1);
    assign w_lane  = byte_lane(w_icode, r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (redirect_i) begin
            w_next = ST_FETCH0;
        end else begin
            case (r_state)
                ST_FETCH0: begin
                    if (imem_ack_i) begin
                        if (imem_err_i || !w_len_ok || w_len == 3'd1) begin
                            w_next = ST_OUT;
                        end else begin
                            w_next = ST_FETCHN;
                        end
                    end
                end
                ST_FETCHN: begin
                    if (imem_ack_i && (imem_err_i || w_last)) begin
                        w_next = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (inst_ready_i) begin
                        if (r_err) begin
                            w_next = ST_ERROR;
                        end else if (w_icode == IC_HALT) begin
                            w_next = ST_HALTED;
                        end else begin
                            w_next = ST_FETCH0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A faulting byte is never packed, so the delivered word holds only bytes that arrived cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_cnt  <= 3'd0;
            r_len  <= 3'd0;
            r_inst <= '0;
            r_err  <= 1'b0;
        end else if (redirect_i) begin
            r_pc   <= redirect_pc_i;
            r_cnt  <= 3'd0;
            r_len  <= 3'd0;
            r_inst <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH0: begin
                    if (imem_ack_i) begin
                        r_cnt <= 3'd1;
                        if (imem_err_i) begin
                            r_inst <= '0;
                            r_len  <= 3'd1;
                            r_err  <= 1'b1;
                        end else begin
                            r_inst <= {imem_rdata_i, {(INST_W-8){1'b0}}};
                            r_len  <= w_len;
                            r_err  <= !w_len_ok;
                        end
                    end
                end
                ST_FETCHN: begin
                    if (imem_ack_i) begin
                        if (imem_err_i) begin
                            r_err <= 1'b1;
                        end else begin
                            r_inst[{w_lane, 3'b000} +: 8] <= imem_rdata_i;
                            r_cnt                         <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (inst_ready_i) begin
                        r_pc  <= r_pc + {{(PC_W-3){1'b0}}, r_len};
                        r_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req_o   = (r_state == ST_FETCH0) || (r_state == ST_FETCHN);
    assign imem_addr_o  = r_pc + {{(PC_W-3){1'b0}}, r_cnt};
    assign inst_o       = r_inst;
    assign pc_o         = r_pc;
    assign len_o        = r_len;
    assign inst_valid_o = (r_state == ST_OUT);
    assign halted_o     = (r_state == ST_HALTED);
    assign err_o        = r_err;

endmodule

// File: tb/tb_y86_fetch.sv
// tb/tb_y86_fetch.sv - self-checking bench for y86_fetch
module tb_y86_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        imem_err;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [47:0] inst;
    logic [15:0] pc;
    logic [2:0]  len;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;
    logic        err;

    logic [7:0]  mem [0:65535];
    bit          ack_rand;
    bit          err_en;
    logic [15:0] err_addr;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] addr;
        logic [47:0] raw;
        logic [47:0] exp_inst;
        logic [2:0]  exp_len;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [47:0] inst;
        logic [15:0] pc;
        logic [2:0]  len;
    } exp_t;

    vec_t vecs[13];
    exp_t exp_q[$];

    y86_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr_o   (imem_addr),
        .imem_req_o    (imem_req),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .imem_err_i    (imem_err),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_o        (inst),
        .pc_o          (pc),
        .len_o         (len),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (inst_ready),
        .halted_o      (halted),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: answers in the same cycle as the request, optionally with random wait cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        imem_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req && (!ack_rand || $urandom_range(0, 2) != 0)) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                imem_err   = err_en && (imem_addr == err_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 8'h00;
                imem_err   = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 5;
            4'h3, 4'h4, 4'h5:       return 6;
            default:                return 0;
        endcase
    endfunction

    function automatic logic [47:0] model_inst(input logic [47:0] raw);
        logic [7:0] b0, b1, b2, b3, b4, b5;
        b0 = raw[47:40]; b1 = raw[39:32]; b2 = raw[31:24];
        b3 = raw[23:16]; b4 = raw[15:8];  b5 = raw[7:0];
        case (model_len(b0[7:4]))
            2:       return {b0, b1, 32'h0};
            5:       return {b0, b4, b3, b2, b1, 8'h00};
            6:       return {b0, b1, b5, b4, b3, b2};
            default: return {b0, 40'h0};
        endcase
    endfunction

    task automatic load_bytes(input logic [15:0] addr, input logic [47:0] raw, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            mem[a] = raw[47-8*i -: 8];
        end
    endtask

    task automatic do_redirect(input logic [15:0] a);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = a;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid) check({name, "_timeout"}, 64'(inst_valid), 64'd1);
    endtask

    task automatic wait_addr(input logic [15:0] a, output bit found);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (imem_req && imem_addr == a) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        bit          found;
        logic [15:0] ppc;
        logic [47:0] raw;
        int          l;

        checks = 0; failures = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; inst_ready = 1'b1;
        ack_rand = 1'b0; err_en = 1'b0; err_addr = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h10;

        vecs[0]  = '{16'h0300, 48'h100000000000, 48'h100000000000, 3'd1, 1'b0};
        vecs[1]  = '{16'h0310, 48'h201200000000, 48'h201200000000, 3'd2, 1'b0};
        vecs[2]  = '{16'h0320, 48'h30F278563412, 48'h30F212345678, 3'd6, 1'b0};
        vecs[3]  = '{16'h0330, 48'h401504030201, 48'h401501020304, 3'd6, 1'b0};
        vecs[4]  = '{16'h0340, 48'h5037EFBEADDE, 48'h5037DEADBEEF, 3'd6, 1'b0};
        vecs[5]  = '{16'h0350, 48'h600100000000, 48'h600100000000, 3'd2, 1'b0};
        vecs[6]  = '{16'h0360, 48'h734433221100, 48'h731122334400, 3'd5, 1'b0};
        vecs[7]  = '{16'h0370, 48'h800001000000, 48'h800000010000, 3'd5, 1'b0};
        vecs[8]  = '{16'h0380, 48'h900000000000, 48'h900000000000, 3'd1, 1'b0};
        vecs[9]  = '{16'h0390, 48'hA04F00000000, 48'hA04F00000000, 3'd2, 1'b0};
        vecs[10] = '{16'h03A0, 48'hB03F00000000, 48'hB03F00000000, 3'd2, 1'b0};
        vecs[11] = '{16'hFFFD, 48'h30F301000080, 48'h30F380000001, 3'd6, 1'b0};
        vecs[12] = '{16'h0400, 48'hE00000000000, 48'hE00000000000, 3'd1, 1'b1};

        // Reset values
        mem[0] = 8'h10; mem[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_len", 64'(len), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);

        // nop, halt from RESET_PC
        rst = 1'b0;
        wait_valid("nop0");
        check("nop0_icode", 64'(inst[47:40]), 64'h10);
        check("nop0_pc", 64'(pc), 64'h0);
        check("nop0_len", 64'(len), 64'd1);
        @(negedge clk);
        wait_valid("halt1");
        check("halt1_icode", 64'(inst[47:40]), 64'h00);
        check("halt1_pc", 64'(pc), 64'h1);
        check("halt1_halted_early", 64'(halted), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("halt_halted", 64'(halted), 64'd1);
            check("halt_req", 64'(imem_req), 64'd0);
            check("halt_valid", 64'(inst_valid), 64'd0);
            @(negedge clk);
        end

        // Table of single instructions reached by redirect
        for (int v = 0; v < 13; v++) begin
            load_bytes(vecs[v].addr, vecs[v].raw, 6);
            do_redirect(vecs[v].addr);
            wait_valid("vec");
            check($sformatf("vec%0d_inst", v), 64'(inst), 64'(vecs[v].exp_inst));
            check($sformatf("vec%0d_pc", v), 64'(pc), 64'(vecs[v].addr));
            check($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
            if (!vecs[v].exp_err) begin
                check($sformatf("vec%0d_len", v), 64'(len), 64'(vecs[v].exp_len));
            end else begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    check("bad_valid_once", 64'(inst_valid), 64'd0);
                    check("bad_req", 64'(imem_req), 64'd0);
                    check("bad_err_held", 64'(err), 64'd1);
                    @(negedge clk);
                end
            end
        end

        // Decode stall: outputs hold, no requests, then accept and advance pc
        inst_ready = 1'b0;
        do_redirect(16'h0320);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_inst", 64'(inst), 64'h30F212345678);
            check("stall_pc", 64'(pc), 64'h0320);
            check("stall_req", 64'(imem_req), 64'd0);
            @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        check("stall_accept_valid", 64'(inst_valid), 64'd0);
        check("stall_next_pc", 64'(pc), 64'h0326);
        check("stall_next_req", 64'(imem_req), 64'd1);

        // Redirect while fetching byte 2 of a 6-byte instruction, with that byte acked
        load_bytes(16'h0040, 48'h30F278563412, 6);
        mem[16'h0200] = 8'h10;
        do_redirect(16'h0040);
        wait_addr(16'h0042, found);
        check("rdr_found", 64'(found), 64'd1);
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        check("rdr_addr", 64'(imem_addr), 64'h0200);
        check("rdr_req", 64'(imem_req), 64'd1);
        check("rdr_valid", 64'(inst_valid), 64'd0);
        wait_valid("rdr");
        check("rdr_pc", 64'(pc), 64'h0200);
        check("rdr_inst", 64'(inst), 64'h100000000000);

        // Memory fault on byte 2
        err_en = 1'b1; err_addr = 16'h0322;
        do_redirect(16'h0320);
        wait_valid("merr");
        check("merr_err", 64'(err), 64'd1);
        check("merr_inst", 64'(inst), 64'h30F200000000);
        check("merr_pc", 64'(pc), 64'h0320);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("merr_valid_once", 64'(inst_valid), 64'd0);
            check("merr_req", 64'(imem_req), 64'd0);
            check("merr_err_held", 64'(err), 64'd1);
            @(negedge clk);
        end
        err_en = 1'b0;

        // Reset in the middle of an instruction
        do_redirect(16'h0320);
        wait_addr(16'h0323, found);
        check("mrst_found", 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mrst_pc", 64'(pc), 64'h0);
        check("mrst_inst", 64'(inst), 64'h0);
        check("mrst_len", 64'(len), 64'd0);
        check("mrst_addr", 64'(imem_addr), 64'h0);

        // Random program with memory wait states and decode back-pressure
        ppc = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            raw = {4'($urandom_range(1, 11)), 4'($urandom_range(0, 15)), 8'($urandom), 32'($urandom)};
            l = model_len(raw[47:44]);
            load_bytes(ppc, raw, l);
            exp_q.push_back('{model_inst(raw), ppc, 3'(l)});
            ppc = ppc + 16'(l);
        end
        mem[ppc] = 8'h00;
        exp_q.push_back('{48'h0, ppc, 3'd1});
        ack_rand = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 5000 && !(exp_q.size() == 0 && halted); cyc++) begin
            @(negedge clk);
            inst_ready = 1'($urandom_range(0, 1));
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_extra: got inst %h pc %h expected no transfer", inst, pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rnd_inst", 64'(inst), 64'(e.inst));
                    check("rnd_pc", 64'(pc), 64'(e.pc));
                    check("rnd_len", 64'(len), 64'(e.len));
                    check("rnd_err", 64'(err), 64'd0);
                end
            end
        end
        check("rnd_remaining", 64'(exp_q.size()), 64'd0);
        check("rnd_halted", 64'(halted), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
